// File: rtl/inst_loader_pkg.sv
// Shared types and helpers for the boot-time instruction loader.
// Loader state encodings live here so the FSM and any observers agree on them.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    LDR_LEN  = 3'd0,
    LDR_DATA = 3'd1,
    LDR_CHK  = 3'd2,
    LDR_DONE = 3'd3,
    LDR_ERR  = 3'd4
  } ldr_state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Byte address of word k; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] k);
    return base + {k[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; the first byte of a
// word lands in bits [7:0]. word/word_ready are valid in the 4th byte's cycle.
module byte_packer (
  input  logic        clk,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  idx;
  logic [23:0] partial;

  // Each new byte enters at the top and older bytes shift down, so after
  // four bytes the oldest sits at [7:0].
  assign word       = {byte_data, partial};
  assign word_ready = byte_valid && (idx == 2'd3);

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values; mixing in = here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (clear) begin
      idx     <= 2'd0;
      partial <= 24'd0;
    end else if (byte_valid) begin
      idx     <= idx + 2'd1;
      partial <= word[31:8];
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: length-prefixed, XOR-checksummed byte stream into instruction
// memory, holding the core in reset until a load completes cleanly.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  ldr_state_e  state, state_next;
  logic [31:0] n_words;
  logic [31:0] word_cnt;
  logic [7:0]  xsum;

  logic        accept;
  logic        pack_valid;
  logic [31:0] pk_word;
  logic        pk_ready;

  assign in_ready   = !rst && ((state == LDR_LEN) || (state == LDR_DATA) ||
                               (state == LDR_CHK));
  assign accept     = in_valid && in_ready;
  assign pack_valid = accept && ((state == LDR_LEN) || (state == LDR_DATA));

  // The same packer assembles the length word and then every payload word.
  byte_packer u_packer (
    .clk        (clk),
    .clear      (rst),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      LDR_LEN: begin
        if (pk_ready) begin
          if (pk_word == 32'd0)                 state_next = LDR_CHK;
          else if (pk_word > 32'(MEM_WORDS))    state_next = LDR_ERR;
          else                                  state_next = LDR_DATA;
        end
      end
      LDR_DATA: begin
        if (pk_ready && (word_cnt == n_words - 32'd1)) state_next = LDR_CHK;
      end
      LDR_CHK: begin
        if (accept) state_next = (in_data == xsum) ? LDR_DONE : LDR_ERR;
      end
      LDR_DONE: state_next = LDR_DONE;
      LDR_ERR:  state_next = LDR_ERR;
      default:  state_next = LDR_ERR;
    endcase
  end

  // NOTE: reset is synchronous, so it only acts on a rising edge; clearing
  // mem_we here also drops any write that was about to be issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LDR_LEN;
      n_words   <= 32'd0;
      word_cnt  <= 32'd0;
      xsum      <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state  <= state_next;
      mem_we <= 1'b0;

      if (pack_valid) xsum <= xsum ^ in_data;

      if ((state == LDR_LEN) && pk_ready) begin
        n_words  <= pk_word;
        word_cnt <= 32'd0;
      end

      if ((state == LDR_DATA) && pk_ready) begin
        mem_we    <= 1'b1;
        mem_addr  <= word_addr(BASE_ADDR, word_cnt);
        mem_wdata <= pk_word;
        word_cnt  <= word_cnt + 32'd1;
      end

      // Status follows the state being entered, so it is visible right after
      // the checksum (or oversize length) edge.
      done    <= (state_next == LDR_DONE);
      err     <= (state_next == LDR_ERR);
      cpu_rst <= (state_next != LDR_DONE);
    end
  end

endmodule
